// File: rtl/ejercicio_3.sv
// rtl/ejercicio_3.sv - button-stepped 3-bit Gray-code Moore sequencer (optional BOTON_EDGE_EN)
module ejercicio_3 #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic boton,
   output logic Y1,
   output logic Y2,
   output logic Y3
);

   typedef enum logic [2:0] {
      S0 = 3'b000,
      S1 = 3'b001,
      S2 = 3'b011,
      S3 = 3'b010,
      S4 = 3'b110,
      S5 = 3'b111,
      S6 = 3'b101,
      S7 = 3'b100
   } state_t;

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_boton_s;
   logic                   w_advance;
   state_t                 r_state;
   state_t                 w_state_next;

   // Bring the raw button level into the clk domain through a flip-flop chain
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], boton};
      end
   end

   assign w_boton_s = r_sync[SYNC_STAGES-1];

`ifdef BOTON_EDGE_EN
   logic r_boton_prev;

   // Remember the previous synchronized level so only a fresh press advances
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_boton_prev <= 1'b0;
      end else begin
         r_boton_prev <= w_boton_s;
      end
   end

   assign w_advance = w_boton_s & ~r_boton_prev;
`else
   assign w_advance = w_boton_s;
`endif

   // State register; reset abandons any position in the sequence
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S0;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Successor in the Gray sequence, taken only when the advance condition holds
   always_comb begin
      w_state_next = r_state;
      if (w_advance) begin
         case (r_state)
            S0:      w_state_next = S1;
            S1:      w_state_next = S2;
            S2:      w_state_next = S3;
            S3:      w_state_next = S4;
            S4:      w_state_next = S5;
            S5:      w_state_next = S6;
            S6:      w_state_next = S7;
            S7:      w_state_next = S0;
            default: w_state_next = S0;
         endcase
      end
   end

   // Moore outputs are the state bits themselves
   always_comb begin
      {Y1, Y2, Y3} = r_state;
   end

endmodule

// File: tb/tb_ejercicio_3.sv
// tb/tb_ejercicio_3.sv - directed self-checking bench for ejercicio_3 (both build modes)
module tb_ejercicio_3;

   logic       clk;
   logic       reset;
   logic       boton;
   logic       y1, y2, y3;
   logic       z1, z2, z3;
   logic [2:0] w_out;
   logic [2:0] w_out3;
   logic [2:0] prev;
   int         total;
   int         bad;

   logic [2:0] seq [0:7] = '{3'b000, 3'b001, 3'b011, 3'b010,
                             3'b110, 3'b111, 3'b101, 3'b100};

   ejercicio_3 #(.SYNC_STAGES(2)) dut (
      .clk   (clk),
      .reset (reset),
      .boton (boton),
      .Y1    (y1),
      .Y2    (y2),
      .Y3    (y3)
   );

   ejercicio_3 #(.SYNC_STAGES(3)) dut3 (
      .clk   (clk),
      .reset (reset),
      .boton (boton),
      .Y1    (z1),
      .Y2    (z2),
      .Y3    (z3)
   );

   assign w_out  = {y1, y2, y3};
   assign w_out3 = {z1, z2, z3};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      total = total + 1;
      if (obs !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %b expected %b", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge and settle 1 time unit after it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      boton = 1'b0;

      // Reset takes effect without a clock edge
      #2;
      reset = 1'b0;
      #1;
      chk("reset_immediate", w_out, 3'b000);
      chk("reset_immediate_s3", w_out3, 3'b000);
      step();
      step();
      chk("reset_held", w_out, 3'b000);

`ifdef BOTON_EDGE_EN
      // Three 5-cycle presses separated by 4 low cycles -> three steps
      reset = 1'b1;
      step();
      step();
      step();
      chk("edge_idle", w_out, 3'b000);
      for (int p = 0; p < 3; p++) begin
         boton = 1'b1;
         for (int c = 0; c < 5; c++) step();
         boton = 1'b0;
         for (int c = 0; c < 4; c++) step();
      end
      for (int c = 0; c < 4; c++) step();
      chk("edge_three_presses", w_out, 3'b010);
      chk("edge_three_presses_s3", w_out3, 3'b010);

      // One long press -> exactly one step
      reset = 1'b0;
      #1;
      chk("edge_reset", w_out, 3'b000);
      step();
      reset = 1'b1;
      step();
      boton = 1'b1;
      for (int c = 0; c < 50; c++) step();
      chk("edge_long_press_held", w_out, 3'b001);
      boton = 1'b0;
      for (int c = 0; c < 4; c++) step();
      chk("edge_long_press", w_out, 3'b001);
      chk("edge_long_press_s3", w_out3, 3'b001);

      // Button held through reset release -> exactly one step, same latency as level mode
      reset = 1'b0;
      boton = 1'b1;
      step();
      reset = 1'b1;
      step();
      step();
      chk("edge_rel_e1", w_out, 3'b000);
      step();
      chk("edge_rel_e2", w_out, 3'b001);
      for (int c = 0; c < 10; c++) step();
      chk("edge_rel_held", w_out, 3'b001);
      chk("edge_rel_held_s3", w_out3, 3'b001);
      boton = 1'b0;
`else
      // Level stepping with button held high through reset release
      boton = 1'b1;
      step();
      reset = 1'b1;
      step();
      chk("lvl_edge0", w_out, 3'b000);
      chk("lvl_edge0_s3", w_out3, 3'b000);
      step();
      chk("lvl_edge1", w_out, 3'b000);
      chk("lvl_edge1_s3", w_out3, 3'b000);
      step();
      chk("lvl_edge2", w_out, 3'b001);
      chk("lvl_edge2_s3", w_out3, 3'b000);
      step();
      chk("lvl_edge3", w_out, 3'b011);
      chk("lvl_edge3_s3", w_out3, 3'b001);
      for (int e = 4; e <= 10; e++) begin
         step();
         chk($sformatf("lvl_edge%0d", e), w_out, seq[(e - 1) % 8]);
      end

      // Hold: button dropped before the edge that reaches S3
      step();
      chk("hold_pre", w_out, 3'b011);
      boton = 1'b0;
      step();
      chk("hold_s3", w_out, 3'b010);
      step();
      chk("hold_last_step", w_out, 3'b110);
      for (int c = 0; c < 20; c++) begin
         step();
         chk($sformatf("hold_c%0d", c), w_out, 3'b110);
      end

      // Gray property over 64 steps; 64 steps returns to the starting state
      boton = 1'b1;
      step();
      step();
      prev = w_out;
      for (int s = 0; s < 64; s++) begin
         step();
         chk($sformatf("gray_s%0d", s), 3'($countones(w_out ^ prev)), 3'd1);
         prev = w_out;
      end
      chk("gray_wrap64", w_out, 3'b110);

      // Reset mid-sequence while in S5, between clock edges
      boton = 1'b0;
      reset = 1'b0;
      #1;
      chk("reset_again", w_out, 3'b000);
      boton = 1'b1;
      step();
      reset = 1'b1;
      for (int e = 0; e <= 6; e++) step();
      chk("mid_s5", w_out, 3'b111);
      #2;
      reset = 1'b0;
      #1;
      chk("mid_reset_async", w_out, 3'b000);
      chk("mid_reset_async_s3", w_out3, 3'b000);
      boton = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
